// File: rtl/fp32_add_arbiter_pkg.sv
// Shared definitions for the FP32 adder arbiter and its tag pipeline.
package fp32_add_arbiter_pkg;

    localparam int FP_W        = 32;
    localparam int ADD_LAT_DEF = 6;
    localparam int ID_MAX_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp32_add_arbiter_if.sv
// Requester-side bundle: operand requests with grant, and tagged responses.
interface fp32_add_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import fp32_add_arbiter_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [FP_W*NREQ-1:0] req_a;
    logic [FP_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [FP_W-1:0]      rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/fp32_add_arbiter_rr_arbiter_nreq.sv
// Combinational round-robin grant: searches from ptr+1 upward, modulo N.
module rr_arbiter_nreq #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gid
);

    int          idx;
    logic [IW-1:0] sel;
    logic        found;

    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            sel = IW'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                gid        = sel;
            end
        end
    end

endmodule

// File: rtl/fp32_add_arbiter.sv
// Shares one fixed-latency FP32 adder among NREQ requesters, returning
// each result to its owner through a tag pipeline matched to the adder.
module fp32_add_arbiter
    import fp32_add_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int IDW     = 2
) (
    input  logic            clk_n,
    input  logic            rst_n,
    fp32_add_arbiter_if.slave req_if,
    output logic [FP_W-1:0] add_a,
    output logic [FP_W-1:0] add_b,
    input  logic [FP_W-1:0] add_result,
    output logic            busy
);

    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic            issue;
    tag_t            tags [ADD_LAT];
    tag_t            last;

    rr_arbiter_nreq #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req   (req_if.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gid   (gid)
    );

    // Grant is masked in reset so every output reads zero while rst_n is low.
    always_comb begin
        req_if.req_ready = rst_n ? grant : '0;
        issue            = |req_if.req_ready;
    end

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_if.req_ready[i]) begin
                add_a = req_if.req_a[FP_W*i +: FP_W];
                add_b = req_if.req_b[FP_W*i +: FP_W];
            end
        end
    end

    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IDW'(NREQ - 1);
            for (int k = 0; k < ADD_LAT; k++) begin
                tags[k] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr <= gid;
            end
            tags[0] <= '{valid: issue, id: ID_MAX_W'(gid)};
            for (int k = 1; k < ADD_LAT; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign last = tags[ADD_LAT-1];

    always_comb begin
        req_if.rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_if.rsp_valid[i] = last.valid && (last.id == ID_MAX_W'(i));
        end
        req_if.rsp_id   = last.valid ? last.id[IDW-1:0] : '0;
        req_if.rsp_data = last.valid ? add_result : '0;
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < ADD_LAT; k++) begin
            busy = busy | tags[k].valid;
        end
    end

endmodule

// File: doc/fp32_add_arbiter.md
Name: fp32_add_arbiter

Overview:
- Shares one pipelined FP32 adder (fixed 6-edge latency, no stall, negedge-clocked) between NREQ requesters.
- Round-robin arbitration picks at most one operand pair per cycle and drives it onto the adder.
- A tag pipeline tracks which requester owns each in-flight operation, and the result is returned to that requester.
- Sits between the approximation-engine sub-units and the shared adder instance; the adder is wired at the parent level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 6, adder latency in clk_n falling edges, from operand capture to result register update.
- IDW, 2, requester id width; must equal clog2(NREQ), minimum 1.

Ports:
- clk_n  in  1  clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  32*NREQ  packed operand A; requester i at [32*i+31:32*i].
- req_b  in  32*NREQ  packed operand B, same packing.
- req_ready  out  NREQ  one-hot grant; request i is issued on the edge where req_valid[i] and req_ready[i] are both high.
- add_a  out  32  operand A to the adder.
- add_b  out  32  operand B to the adder.
- add_result  in  32  adder result.
- rsp_valid  out  NREQ  one-hot, one cycle, result valid for requester i.
- rsp_id  out  IDW  index of the owning requester.
- rsp_data  out  32  result, shared by all requesters.
- busy  out  1  any operation in flight.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0 or on its assertion:
  - rr_ptr is set to NREQ-1, so requester 0 has first priority.
  - All tag valids are cleared.
  - All outputs are 0.
- Reset mid-operation drops in-flight results silently; no rsp_valid is produced for them after reset release.
- Arbitration is combinational from req_valid and rr_ptr:
  - Priority order is rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - req_ready is one-hot on the first valid requester in that order, and all-zero when no request is valid.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Issue: on a falling edge with any grant:
  - rr_ptr is loaded with the granted index.
  - tag[0] is loaded with {1, id}.
  - The adder captures add_a/add_b on the same edge.
  - With no grant, rr_ptr holds and tag[0] is loaded with valid=0.
- Operand mux:
  - add_a/add_b carry the granted requester's operands.
  - With no grant they carry 32'h0, so the adder computes 0+0 and the result is ignored.
- Tag pipeline:
  - ADD_LAT entries of {valid, id}, shifted every falling edge with no stall.
  - An issue at edge k appears at tag[ADD_LAT-1] after edge k+ADD_LAT-1, aligned with add_result updating at edge k+ADD_LAT-1.
- Response:
  - rsp_valid[i] = tag[ADD_LAT-1].valid && tag[ADD_LAT-1].id==i.
  - rsp_id = tag id, and rsp_data = add_result when valid.
  - When not valid, rsp_id and rsp_data are forced to 0.
  - There is no backpressure: requesters must accept a response in the cycle it is presented.
- Throughput is one issue per cycle. Back-to-back issues from the same requester are legal when it is the only one requesting.
- Fairness: with all NREQ requesting continuously, the grant sequence is 0,1,…,NREQ-1 repeating. No requester waits more than NREQ-1 issues.
- busy = OR of all tag valids.
- Ordering: responses to a given requester return in issue order, which is guaranteed by the fixed latency.
- Simultaneous events: an issue and a response on the same edge are independent; the pipeline shifts and loads together.
- Arithmetic:
  - rr_ptr modulo wrap at NREQ-1 → 0.
  - With NREQ not a power of two, id codes ≥ NREQ never occur.

Decomposition:
- Shared package: FP32 width constant (32), ADD_LAT default, and the tag struct {valid, id}.
- One sub-module, rr_arbiter_nreq: combinational round-robin grant from a request vector and pointer, reusable by other shared-unit arbiters.
- Tag pipeline and operand mux stay in the top level.

Test Plan:
- Single requester: req 0 issues 0x3F800000 + 0x40000000 at edge k → rsp_valid=4'b0001, rsp_id=0, rsp_data=0x40400000 after edge k+5; busy falls after edge k+6.
- All four requesters request continuously, each with distinct operands (req i: A = i+1.0, B = 1.0) → grants 0,1,2,3,0,… on consecutive edges; responses return in the same order, 5 edges later, with correct sums (2.0 0x40000000, 3.0, 4.0 0x40800000, 5.0 0x40A00000).
- Round-robin after idle: requester 2 granted, then requests from 0 and 3 arrive together → requester 3 is granted first, then 0.
- Idle gaps: requester 1 issues 0x3FC00000 + 0x40200000, idles 2 cycles, then issues again → exactly two rsp_valid pulses, each 0x40800000, with no spurious pulses in between; add_a/add_b = 0 while idle.
- Reset mid-operation: issue 3 operations, then assert rst_n low for 1 cycle → no rsp_valid afterwards; the next request from requester 0 is granted first.
- Continuous single requester with 10 back-to-back issues → 10 consecutive rsp_valid pulses with data in issue order.
